// File: rtl/aes_reg_core_if.sv
// Byte bus between software and the AES register core: write port, read port, start and done.
interface aes_reg_core_if;
  logic [7:0] DIN;
  logic [6:0] ADDR;
  logic       WR;
  logic       START;
  logic       OK;
  logic [7:0] DOUT;

  modport master (
    output DIN,
    output ADDR,
    output WR,
    output START,
    input  OK,
    input  DOUT
  );

  modport slave (
    input  DIN,
    input  ADDR,
    input  WR,
    input  START,
    output OK,
    output DOUT
  );
endinterface

// File: rtl/aes_reg_core.sv
// Register-mapped iterative AES-128/192/256 encryption core, one round per clock.
// The key schedule runs on the fly: an 8-word window holds the most recent expanded words and
// four new words are generated every round, with at most one SubWord per cycle.
module aes_reg_core (
  input logic           CLK,
  input logic           RSTB,
  aes_reg_core_if.slave bus
);

  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit 2047 - 8x, i.e. {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTbl[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [0:15][7:0] st_q, st_d;
  logic [31:0]      kw_q [8];
  logic [31:0]      kw_d [8];
  logic [1:0]       ph_q, ph_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [7:0]       pt_q [16];
  logic [7:0]       pt_d [16];
  logic [7:0]       ct_q [16];
  logic [7:0]       ct_d [16];
  logic [7:0]       key_q [32];
  logic [7:0]       key_d [32];
  logic             en_q, en_d;
  logic [1:0]       klen_q, klen_d;
  logic [7:0]       dout_q, dout_d;

  logic             busy, ok, start_ok, k192, k256, last_round;
  logic [3:0]       nr;
  logic [7:0]       rdata;
  logic [31:0]      key_w [8];
  logic [31:0]      s_in, s_rot, g, n0, n1, n2, n3;
  logic             sub_en, rot_en, at2;
  logic [0:15][7:0] sb, sr, mc, rnd_out;
  logic [0:3][31:0] rk;

  assign busy       = (state_q == StBusy);
  assign ok         = (state_q == StDone);
  assign start_ok   = bus.START && en_q && !busy;
  assign k192       = (klen_q == 2'd2);
  assign k256       = (klen_q == 2'd3);
  assign nr         = k256 ? 4'd14 : (k192 ? 4'd12 : 4'd10);
  assign last_round = (round_q == nr);
  assign bus.OK     = ok;
  assign bus.DOUT   = dout_q;

  // Register read mux.
  always_comb begin
    rdata = '0;
    if (!bus.ADDR[6]) begin
      if (bus.ADDR[5])      rdata = key_q[bus.ADDR[4:0]];
      else if (bus.ADDR[4]) rdata = ct_q[bus.ADDR[3:0]];
      else                  rdata = pt_q[bus.ADDR[3:0]];
    end else begin
      case (bus.ADDR[5:0])
        6'd0:    rdata = {7'd0, en_q};
        6'd1:    rdata = {6'd0, klen_q};
        6'd2:    rdata = {6'd0, ok, busy};
        default: rdata = '0;
      endcase
    end
  end

  // Key schedule: pick the SubWord slot for this round and generate four new words.
  // Window holds w[n-8..n-1]; with Nk=6 the SubWord word can fall at slot 0 or slot 2.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      key_w[j] = {key_q[4*j], key_q[4*j+1], key_q[4*j+2], key_q[4*j+3]};
    end
    sub_en = 1'b1;
    rot_en = 1'b1;
    at2    = 1'b0;
    if (k192) begin
      case (ph_q)
        2'd0:    at2 = 1'b0;
        2'd1:    at2 = 1'b1;
        default: begin
          sub_en = 1'b0;
          rot_en = 1'b0;
        end
      endcase
    end else if (k256) begin
      rot_en = ~ph_q[0];
    end
    // Slot-2 input is w[i-1] computed without the S-box, which keeps the path loop-free.
    s_in  = at2 ? (kw_q[2] ^ kw_q[3] ^ kw_q[7]) : kw_q[7];
    s_rot = rot_en ? {s_in[23:0], s_in[31:24]} : s_in;
    g     = sub_word(s_rot) ^ (rot_en ? {rcon_q, 24'h0} : 32'h0);
    if (k256) begin
      n0 = kw_q[0] ^ g;
      n1 = kw_q[1] ^ n0;
      n2 = kw_q[2] ^ n1;
      n3 = kw_q[3] ^ n2;
      rk = {kw_q[4], kw_q[5], kw_q[6], kw_q[7]};
    end else if (k192) begin
      n0 = kw_q[2] ^ ((sub_en && !at2) ? g : kw_q[7]);
      n1 = kw_q[3] ^ n0;
      n2 = kw_q[4] ^ (at2 ? g : n1);
      n3 = kw_q[5] ^ n2;
      rk = {kw_q[6], kw_q[7], n0, n1};
    end else begin
      n0 = kw_q[4] ^ g;
      n1 = kw_q[5] ^ n0;
      n2 = kw_q[6] ^ n1;
      n3 = kw_q[7] ^ n2;
      rk = {n0, n1, n2, n3};
    end
  end

  // One cipher round: SubBytes, ShiftRows, MixColumns (skipped in the last round), AddRoundKey.
  always_comb begin
    for (int n = 0; n < 16; n++) begin
      sb[n] = sbox(st_q[n]);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} =
        mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
    end
    rnd_out = (last_round ? sr : mc) ^ rk;
  end

  // Next state: register writes, read data, and the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    st_d    = st_q;
    kw_d    = kw_q;
    ph_d    = ph_q;
    rcon_d  = rcon_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    key_d   = key_q;
    en_d    = en_q;
    klen_d  = klen_q;
    dout_d  = dout_q;

    if (bus.WR && !busy) begin
      if (bus.ADDR[6:4] == 3'b000)      pt_d[bus.ADDR[3:0]] = bus.DIN;
      else if (bus.ADDR[6:5] == 2'b01) key_d[bus.ADDR[4:0]] = bus.DIN;
      else if (bus.ADDR == 7'd64)      en_d = bus.DIN[0];
      else if (bus.ADDR == 7'd65)      klen_d = bus.DIN[1:0];
    end
    if (!bus.WR) dout_d = rdata;

    case (state_q)
      StBusy: begin
        st_d = rnd_out;
        for (int j = 0; j < 4; j++) begin
          kw_d[j] = kw_q[j+4];
        end
        kw_d[4] = n0;
        kw_d[5] = n1;
        kw_d[6] = n2;
        kw_d[7] = n3;
        if (rot_en) rcon_d = xtime(rcon_q);
        if (k192)      ph_d = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
        else if (k256) ph_d = {1'b0, ~ph_q[0]};
        else           ph_d = 2'd0;
        if (last_round) begin
          for (int n = 0; n < 16; n++) begin
            ct_d[n] = rnd_out[n];
          end
          state_d = StDone;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: begin
        if (start_ok) begin
          state_d = StBusy;
          round_d = 4'd1;
          ph_d    = 2'd0;
          rcon_d  = 8'h01;
          for (int n = 0; n < 16; n++) begin
            st_d[n] = pt_q[n] ^ key_q[n];
          end
          // Key words occupy the newest Nk slots of the window.
          kw_d = '{default: '0};
          if (k256) begin
            kw_d = key_w;
          end else if (k192) begin
            for (int j = 0; j < 6; j++) begin
              kw_d[j+2] = key_w[j];
            end
          end else begin
            for (int j = 0; j < 4; j++) begin
              kw_d[j+4] = key_w[j];
            end
          end
        end
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= StIdle;
      round_q <= '0;
      st_q    <= '0;
      kw_q    <= '{default: '0};
      ph_q    <= '0;
      rcon_q  <= '0;
      pt_q    <= '{default: '0};
      ct_q    <= '{default: '0};
      key_q   <= '{default: '0};
      en_q    <= 1'b0;
      klen_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
      kw_q    <= kw_d;
      ph_q    <= ph_d;
      rcon_q  <= rcon_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      key_q   <= key_d;
      en_q    <= en_d;
      klen_q  <= klen_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_aes_reg_core.sv
// Directed bench for aes_reg_core: FIPS-197 known answers for all key sizes plus gating,
// restart and asynchronous reset behaviour.
module tb_aes_reg_core;
  logic clk;
  logic rstb;
  int   checks;
  int   errors;

  aes_reg_core_if bus_if ();

  aes_reg_core dut (
    .CLK  (clk),
    .RSTB (rstb),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    bus_if.WR   = 1'b1;
    bus_if.ADDR = a;
    bus_if.DIN  = d;
    @(negedge clk);
    bus_if.WR   = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    bus_if.WR   = 1'b0;
    bus_if.ADDR = a;
    @(negedge clk);
    d = bus_if.DOUT;
  endtask

  task automatic pulse_start;
    bus_if.START = 1'b1;
    @(negedge clk);
    bus_if.START = 1'b0;
  endtask

  // cnt counts rising edges with the START edge as edge 1.
  task automatic wait_ok(input int cnt0, output int cnt);
    cnt = cnt0;
    while (!bus_if.OK && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic read_ct(output logic [127:0] ct);
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      rd(7'(16 + i), b);
      ct[127 - 8*i -: 8] = b;
    end
  endtask

  initial begin
    logic [7:0]   b;
    logic [7:0]   acc;
    logic [127:0] ct;
    logic [127:0] exp128, exp192, exp256;
    int           cnt;

    checks = 0;
    errors = 0;
    exp128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    exp192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    exp256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    rstb         = 1'b0;
    bus_if.WR    = 1'b0;
    bus_if.ADDR  = '0;
    bus_if.DIN   = '0;
    bus_if.START = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ok", 128'(bus_if.OK), 128'd0);
    check("reset_dout", 128'(bus_if.DOUT), 128'd0);
    rstb = 1'b1;
    @(negedge clk);

    rd(7'd66, b);
    check("reset_status", 128'(b), 128'h00);
    rd(7'd64, b);
    check("reset_ctrl", 128'(b), 128'h00);

    // Key 00..0f and plaintext 00112233..ff.
    for (int i = 0; i < 16; i++) begin
      wr(7'(32 + i), 8'(i));
      wr(7'(i), 8'(i * 17));
    end
    wr(7'd65, 8'h01);
    rd(7'd5, b);
    check("pt5_readback", 128'(b), 128'h55);
    rd(7'd65, b);
    check("klen_readback", 128'(b), 128'h01);

    // EN still 0: START must be ignored.
    pulse_start();
    rd(7'd66, b);
    check("gate_status", 128'(b), 128'h00);
    check("gate_ok", 128'(bus_if.OK), 128'd0);

    wr(7'd64, 8'hff);
    rd(7'd64, b);
    check("ctrl_reserved", 128'(b), 128'h01);

    // AES-128 with a PT write attempted while busy.
    pulse_start();
    rd(7'd66, b);
    check("busy_status", 128'(b), 128'h01);
    wr(7'd0, 8'haa);
    wait_ok(3, cnt);
    check("lat128", 128'(cnt), 128'd11);
    read_ct(ct);
    check("ct128", ct, exp128);
    rd(7'd0, b);
    check("pt_busy_write", 128'(b), 128'h00);
    wr(7'd16, 8'h12);
    rd(7'd16, b);
    check("ct_write_ignored", 128'(b), 128'h69);

    // AES-192: key bytes 16..23.
    for (int i = 16; i < 24; i++) wr(7'(32 + i), 8'(i));
    wr(7'd65, 8'h02);
    pulse_start();
    wait_ok(1, cnt);
    check("lat192", 128'(cnt), 128'd13);
    read_ct(ct);
    check("ct192", ct, exp192);

    // AES-256: key bytes 24..31.
    for (int i = 24; i < 32; i++) wr(7'(32 + i), 8'(i));
    wr(7'd65, 8'h03);
    pulse_start();
    wait_ok(1, cnt);
    check("lat256", 128'(cnt), 128'd15);
    read_ct(ct);
    check("ct256", ct, exp256);
    rd(7'd66, b);
    check("done_status", 128'(b), 128'h02);

    // Restart from DONE.
    repeat (32) @(negedge clk);
    check("ok_hold", 128'(bus_if.OK), 128'd1);
    pulse_start();
    check("ok_drop", 128'(bus_if.OK), 128'd0);
    wait_ok(1, cnt);
    check("lat_repeat", 128'(cnt), 128'd15);
    read_ct(ct);
    check("ct_repeat", ct, exp256);

    // Asynchronous reset mid-encryption.
    pulse_start();
    repeat (4) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    check("abort_ok", 128'(bus_if.OK), 128'd0);
    check("abort_dout", 128'(bus_if.DOUT), 128'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    acc = '0;
    for (int a = 0; a < 128; a++) begin
      rd(7'(a), b);
      acc = acc | b;
    end
    check("post_reset_all_zero", 128'(acc), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
